paddle: RTL

Generates one player's 16-row paddle mask for the pong playfield from a rotary quadrature encoder or, in auto mode, from the ball's row. It is the producer side of the `lpaddle`/`rpaddle` interface consumed by the ball logic. Two instances drive the left and right paddles. It runs on the same ~2000 Hz game clock as the ball.

---
 rtl/pong_pkg.sv | 15 +
 rtl/quad_decoder.sv | 27 ++
 rtl/paddle.sv | 78 +++++++
 3 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - playfield geometry, row types and paddle mask helper shared by pong blocks
package pong_pkg;
  localparam int SCREEN_ROWS = 16;
  localparam int ROW_BITS    = 4;

  typedef logic [ROW_BITS-1:0]    row_t;
  typedef logic [SCREEN_ROWS-1:0] row_mask_t;

  // One extra bit so a full-height run of ones can be formed before shifting.
  function automatic row_mask_t paddle_mask(input int unsigned width, input row_t bottom);
    logic [SCREEN_ROWS:0] ones;
    ones = ((SCREEN_ROWS+1)'(1) << width) - (SCREEN_ROWS+1)'(1);
    return ones[SCREEN_ROWS-1:0] << bottom;
  endfunction
endpackage

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - encoder synchronizer and detent decode, one step pulse per detent
module quad_decoder (
  input  logic clk,
  input  logic reset,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_up,
  output logic step_dn
);
  logic [1:0] s1, s2, prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 2'b00;
      s2   <= 2'b00;
      prev <= 2'b00;
    end else begin
      s1   <= {enc_a, enc_b};
      s2   <= s1;
      prev <= s2;
    end
  end

  // Only the final edge into the 00 detent counts; everything else just moves prev.
  assign step_up = (prev == 2'b10) && (s2 == 2'b00);
  assign step_dn = (prev == 2'b01) && (s2 == 2'b00);
endmodule

// File: rtl/paddle.sv
// rtl/paddle.sv - paddle position and row mask from encoder detents or ball-tracking auto mode
module paddle
  import pong_pkg::*;
#(
  parameter int PADDLE_WIDTH = 4,
  parameter int AUTO_DIV     = 250
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      enc_a,
  input  logic      enc_b,
  input  logic      auto,
  input  row_t      ball_y,
  output row_t      pos,
  output row_mask_t mask
);
  localparam int MAXPOS = SCREEN_ROWS - PADDLE_WIDTH;
  localparam row_t MAX_ROW  = row_t'(MAXPOS);
  localparam row_t HOME_ROW = row_t'(MAXPOS / 2);
  localparam int CNT_W = $clog2(AUTO_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_DIV - 1);
  localparam logic signed [5:0] HALF_W = 6'(PADDLE_WIDTH / 2);
  localparam logic signed [5:0] MAX_S  = 6'(MAXPOS);

  logic             step_up, step_dn;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic signed [5:0] target_raw;
  row_t             target;
  row_t             pos_next;

  quad_decoder u_dec (
    .clk     (clk),
    .reset   (reset),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || tick) cnt <= '0;
    else               cnt <= cnt + CNT_W'(1);
  end

  // Center the paddle on the ball, clamped so it never leaves the playfield.
  always_comb begin
    target_raw = $signed({2'b00, ball_y}) - HALF_W;
    if (target_raw < 6'sd0)      target = '0;
    else if (target_raw > MAX_S) target = MAX_ROW;
    else                         target = target_raw[ROW_BITS-1:0];
  end

  always_comb begin
    pos_next = pos;
    if (auto) begin
      if (tick) begin
        if (pos < target)      pos_next = pos + row_t'(1);
        else if (pos > target) pos_next = pos - row_t'(1);
      end
    end else begin
      if (step_up && (pos != MAX_ROW))  pos_next = pos + row_t'(1);
      else if (step_dn && (pos != '0))  pos_next = pos - row_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos  <= HOME_ROW;
      mask <= paddle_mask(PADDLE_WIDTH, HOME_ROW);
    end else begin
      pos  <= pos_next;
      mask <= paddle_mask(PADDLE_WIDTH, pos_next);
    end
  end
endmodule
